// File: rtl/imem_loader.sv
// Purpose: boot loader; unpacks a framed byte stream into 32-bit words for instruction memory.
//          It verifies a trailing XOR check byte, then enables the core.
// Latency: the write strobe comes one cycle after the 4th byte of a word is accepted.
//          A full-rate stream takes 5 cycles per word.
// Backpressure: byteReady is registered. It is low in IDLE, WRITE, DONE and ERROR.
//               A byte offered while byteReady is low is not consumed and must be held.
//
// Ports:
//   clk, resetN      : rising-edge clock, async active-low reset
//   byteIn/byteValid : stream byte and its valid; byteReady : loader accepts this cycle
//   memWrite*        : one-cycle write strobe, word byte address (x4), word data
//   cpuEnable/loadDone/loadError : terminal status flags
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWriteEnable,
  output logic [31:0] memWriteAddress,
  output logic [31:0] memWriteData,
  output logic        cpuEnable,
  output logic        loadDone,
  output logic        loadError
);

  typedef enum logic [2:0] {
    IDLE, COUNT_HI, COUNT_LO, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] word_q, word_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  csum_q, csum_d;

  logic        accept;
  logic [15:0] count_rx;

  assign accept   = byteValid && ready_q;
  // Full word count, as it stands once the low byte is on the bus.
  assign count_rx = {count_q[15:8], byteIn};

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;

    case (state_q)
      IDLE: state_d = COUNT_HI;
      COUNT_HI: begin
        if (accept) begin
          count_d = {byteIn, 8'h00};
          csum_d  = csum_q ^ byteIn;
          state_d = COUNT_LO;
        end
      end
      COUNT_LO: begin
        if (accept) begin
          count_d = count_rx;
          csum_d  = csum_q ^ byteIn;
          bcnt_d  = 2'd0;
          if (32'(count_rx) > MAX_WORDS) state_d = ERROR;
          else if (count_rx == 16'd0)    state_d = CHECK;
          else                           state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], byteIn};
          csum_d = csum_q ^ byteIn;
          // The 2-bit counter wraps back to 0 on the 4th byte, which is
          // exactly the value the next word needs.
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // The address output is driven from idx_q, so it stays stable for
        // the whole strobe cycle and advances only after it.
        idx_d   = idx_q + 16'd1;
        state_d = ((idx_q + 16'd1) == count_q) ? CHECK : DATA;
      end
      CHECK: begin
        if (accept) state_d = (byteIn == csum_q) ? DONE : ERROR;
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // Ready is derived from the next state, so it drops on the same edge
    // that enters WRITE, DONE or ERROR. It is held low while leaving IDLE,
    // so it first rises one edge after COUNT_HI is entered.
    ready_d = (state_q != IDLE) &&
              (state_d == COUNT_HI || state_d == COUNT_LO ||
               state_d == DATA     || state_d == CHECK);
    we_d    = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= 32'd0;
      idx_q   <= 16'd0;
      count_q <= 16'd0;
      bcnt_q  <= 2'd0;
      csum_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
      csum_q  <= csum_d;
    end
  end

  assign byteReady       = ready_q;
  assign memWriteEnable  = we_q;
  assign memWriteAddress = {14'd0, idx_q, 2'b00};
  assign memWriteData    = word_q;
  assign cpuEnable       = (state_q == DONE);
  assign loadDone        = (state_q == DONE);
  assign loadError       = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: self-checking bench for imem_loader. Expected writes go into a
//          scoreboard queue, and a negedge monitor pops and compares each strobe.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWriteEnable;
  logic [31:0] memWriteAddress;
  logic [31:0] memWriteData;
  logic        cpuEnable;
  logic        loadDone;
  logic        loadError;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];   // {address, data} of each expected write
  logic [7:0]  frame[16];

  imem_loader #(.MAX_WORDS(256)) dut (
    .clk(clk), .resetN(resetN), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .memWriteEnable(memWriteEnable),
    .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
    .cpuEnable(cpuEnable), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard. A strobe
  // that lasts two cycles pops twice, so it shows up as a mismatch or as an
  // unexpected write.
  always @(negedge clk) begin
    if (resetN && memWriteEnable) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 memWriteAddress, memWriteData);
      end else begin
        chk("write_addr_data", {32'd0, memWriteAddress, memWriteData}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    byteValid = 1'b0;
    byteIn    = 8'h00;
    #2 resetN = 1'b0;
    #1;
    chk("reset_outputs",
        {27'd0, byteReady, memWriteEnable, cpuEnable, loadDone, loadError, memWriteAddress, memWriteData},
        96'd0);
    @(negedge clk) resetN = 1'b1;
    @(posedge clk); #1;
    chk("ready_low_1st_edge", {95'd0, byteReady}, 96'd0);
    @(posedge clk); #1;
    chk("ready_high_2nd_edge", {95'd0, byteReady}, 96'd1);
  endtask

  // Holds the byte until it is accepted on an edge with byteReady high.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (byteReady) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no byteReady expected accept of %0h", b);
    end else begin
      @(posedge clk); #1;
    end
    byteValid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    byteValid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_range(input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      send_byte(frame[i]);
      if (gaps) idle_cycles((i * 7) % 4);
    end
  endtask

  task automatic check_end(input string nm, input logic done, input logic err);
    idle_cycles(2);
    chk({nm, "_cpuEnable"}, {95'd0, cpuEnable}, {95'd0, done});
    chk({nm, "_loadDone"},  {95'd0, loadDone},  {95'd0, done});
    chk({nm, "_loadError"}, {95'd0, loadError}, {95'd0, err});
    chk({nm, "_byteReady"}, {95'd0, byteReady}, 96'd0);
    chk({nm, "_writes_left"}, 96'(exp_q.size()), 96'd0);
  endtask

  task automatic load_nominal(input logic [7:0] chk_byte);
    frame[0] = 8'h00; frame[1] = 8'h02;
    frame[2] = 8'h12; frame[3] = 8'h34; frame[4] = 8'h56; frame[5] = 8'h78;
    frame[6] = 8'h9A; frame[7] = 8'hBC; frame[8] = 8'hDE; frame[9] = 8'hF0;
    frame[10] = chk_byte;
  endtask

  task automatic push_nominal();
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    exp_q.push_back({32'h0000_0004, 32'h9ABC_DEF0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal full-rate load. A byte is offered during the WRITE cycle; it
    // must be held there and taken once ready returns.
    do_reset();
    load_nominal(8'h02);
    push_nominal();
    send_range(0, 5, 1'b0);
    byteIn    = 8'h9A;
    byteValid = 1'b1;
    @(negedge clk);
    chk("write_cycle_ready_we", {94'd0, byteReady, memWriteEnable}, 96'd1);
    send_range(6, 10, 1'b0);
    check_end("nominal", 1'b1, 1'b0);

    // Bad check byte: both words are still written.
    do_reset();
    load_nominal(8'h03);
    push_nominal();
    send_range(0, 10, 1'b0);
    check_end("badsum", 1'b0, 1'b1);

    // Empty image.
    do_reset();
    frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00;
    send_range(0, 2, 1'b0);
    check_end("empty", 1'b1, 1'b0);

    // Overflow: count 257 is rejected on the count low byte.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    chk("overflow_error_now", {95'd0, loadError}, 96'd1);
    byteIn    = 8'hAA;
    byteValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("overflow_ready_low", {95'd0, byteReady}, 96'd0);
    end
    check_end("overflow", 1'b0, 1'b1);

    // Same nominal frame with valid gaps.
    do_reset();
    load_nominal(8'h02);
    push_nominal();
    send_range(0, 10, 1'b1);
    check_end("gaps", 1'b1, 1'b0);

    // Reset after 7 bytes: the first word has already been written.
    do_reset();
    load_nominal(8'h02);
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    send_range(0, 6, 1'b0);
    chk("midload_writes_left", 96'(exp_q.size()), 96'd0);
    do_reset();
    push_nominal();
    send_range(0, 10, 1'b0);
    check_end("after_reset", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
